// File: rtl/vote_filter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vote_filter_n : N-input vote with registered stage and HOLD debounce.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vote_filter_n #(
  parameter  int N    = 3,
  parameter  int HOLD = 4,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  in,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] thr,
  output logic [CW-1:0] cnt,
  output logic          raw,
  output logic          d,
  output logic          change,
  output logic [7:0]    glitch
);

  localparam int              SCW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0]   N_C     = CW'(N);
  localparam logic [CW-1:0]   HALF_C  = CW'(N / 2);
  localparam logic [SCW-1:0]  SC_LAST = SCW'(HOLD - 1);

  logic [CW-1:0]  pop;
  logic           vote;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           raw_q, raw_d;
  logic           d_q, d_d;
  logic           change_q, change_d;
  logic [7:0]     glitch_q, glitch_d;
  logic [SCW-1:0] sc_q, sc_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(in[i]);
    end
  end

  // Majority is strictly greater than half, so an even-N tie votes 0.
  always_comb begin
    vote = 1'b0;
    case (mode)
      2'b00:   vote = (pop > HALF_C);
      2'b01:   vote = (pop != '0);
      2'b10:   vote = (pop == N_C);
      default: vote = (pop >= thr);
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    raw_d    = raw_q;
    d_d      = d_q;
    change_d = 1'b0;
    glitch_d = glitch_q;
    sc_d     = sc_q;
    if (en) begin
      cnt_d = pop;
      raw_d = vote;
      if (raw_q != d_q) begin
        if (sc_q == SC_LAST) begin
          d_d      = raw_q;
          change_d = 1'b1;
          sc_d     = '0;
        end else begin
          sc_d = sc_q + SCW'(1);
        end
      end else if (sc_q != '0) begin
        // raw fell back to d before HOLD elapsed: a rejected glitch
        glitch_d = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;
        sc_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      raw_q    <= 1'b0;
      d_q      <= 1'b0;
      change_q <= 1'b0;
      glitch_q <= 8'd0;
      sc_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      raw_q    <= raw_d;
      d_q      <= d_d;
      change_q <= change_d;
      glitch_q <= glitch_d;
      sc_q     <= sc_d;
    end
  end

  assign cnt    = cnt_q;
  assign raw    = raw_q;
  assign d      = d_q;
  assign change = change_q;
  assign glitch = glitch_q;

endmodule
`default_nettype wire
